// File: rtl/regbank_np.sv
// Parametrised register file: one write port, two registered read ports,
// optional write-first bypass, optional hard-wired zero entry and a soft-clear sequencer.
module regbank_np #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter bit ZERO_REG = 1'b0,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] add_wr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] add_rd0,
    input  logic [ADDR_W-1:0] add_rd1,
    output logic [DATA_W-1:0] rd0,
    output logic [DATA_W-1:0] rd1,
    input  logic              clr_start,
    output logic              busy,
    output logic              clr_done
);
    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_ptr, clr_ptr_nxt;
    logic              clr_done_nxt;
    logic              eff_wr;
    logic [ADDR_W-1:0] eff_addr;
    logic [DATA_W-1:0] eff_data;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd0_nxt, rd1_nxt;

    // Exactly one write source per edge: external port in IDLE, sequencer in CLEAR.
    always_comb begin
        state_nxt    = state;
        clr_ptr_nxt  = clr_ptr;
        clr_done_nxt = 1'b0;
        eff_wr       = 1'b0;
        eff_addr     = add_wr;
        eff_data     = wr_data;
        case (state)
            IDLE: begin
                eff_wr = wr_en && !(ZERO_REG && add_wr == '0);
                if (clr_start) begin
                    state_nxt   = CLEAR;
                    clr_ptr_nxt = '0;
                end
            end
            CLEAR: begin
                eff_wr      = 1'b1;
                eff_addr    = clr_ptr;
                eff_data    = '0;
                clr_ptr_nxt = clr_ptr + ADDR_W'(1);
                if (&clr_ptr) begin
                    state_nxt    = IDLE;
                    clr_done_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd0_nxt = mem[add_rd0];
        rd1_nxt = mem[add_rd1];
        if (BYPASS && eff_wr && eff_addr == add_rd0) rd0_nxt = eff_data;
        if (BYPASS && eff_wr && eff_addr == add_rd1) rd1_nxt = eff_data;
        if (ZERO_REG && add_rd0 == '0) rd0_nxt = '0;
        if (ZERO_REG && add_rd1 == '0) rd1_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            clr_ptr  <= '0;
            clr_done <= 1'b0;
            rd0      <= '0;
            rd1      <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            state    <= state_nxt;
            clr_ptr  <= clr_ptr_nxt;
            clr_done <= clr_done_nxt;
            rd0      <= rd0_nxt;
            rd1      <= rd1_nxt;
            if (eff_wr) mem[eff_addr] <= eff_data;
        end
    end

    assign busy = (state == CLEAR);

endmodule

// File: tb/tb_regbank_np.sv
// Directed bench for regbank_np: three instances (default, read-first, zero-entry)
// share one stimulus stream; expected values are hand-computed constants.
module tb_regbank_np;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] add_wr = '0;
    logic [7:0] wr_data = '0;
    logic [2:0] add_rd0 = '0;
    logic [2:0] add_rd1 = '0;
    logic       clr_start = 1'b0;

    logic [7:0] rd0_d, rd1_d, rd0_nb, rd1_nb, rd0_zr, rd1_zr;
    logic       busy_d, busy_nb, busy_zr, done_d, done_nb, done_zr;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    regbank_np u_def (
        .clk(clk), .reset(reset), .wr_en(wr_en), .add_wr(add_wr), .wr_data(wr_data),
        .add_rd0(add_rd0), .add_rd1(add_rd1), .rd0(rd0_d), .rd1(rd1_d),
        .clr_start(clr_start), .busy(busy_d), .clr_done(done_d)
    );
    regbank_np #(.BYPASS(1'b0)) u_nb (
        .clk(clk), .reset(reset), .wr_en(wr_en), .add_wr(add_wr), .wr_data(wr_data),
        .add_rd0(add_rd0), .add_rd1(add_rd1), .rd0(rd0_nb), .rd1(rd1_nb),
        .clr_start(clr_start), .busy(busy_nb), .clr_done(done_nb)
    );
    regbank_np #(.ZERO_REG(1'b1)) u_zr (
        .clk(clk), .reset(reset), .wr_en(wr_en), .add_wr(add_wr), .wr_data(wr_data),
        .add_rd0(add_rd0), .add_rd1(add_rd1), .rd0(rd0_zr), .rd1(rd1_zr),
        .clr_start(clr_start), .busy(busy_zr), .clr_done(done_zr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill();
        wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            add_wr  = 3'(i);
            wr_data = 8'(8'h80 + i);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total_cnt++;
        if (busy_d !== 1'b0 || done_d !== 1'b0 || rd0_d !== 8'h00 || rd1_d !== 8'h00)
            $display("FAIL reset_outputs: busy=%b done=%b rd0=%h rd1=%h, want 0 0 00 00",
                     busy_d, done_d, rd0_d, rd1_d);
        else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            add_rd0 = 3'(i);
            add_rd1 = 3'(7 - i);
            tick();
            total_cnt++;
            if (rd0_d !== 8'h00 || rd1_d !== 8'h00 || busy_d !== 1'b0 || done_d !== 1'b0)
                $display("FAIL reset_readback[%0d]: rd0=%h rd1=%h busy=%b done=%b, want 00 00 0 0",
                         i, rd0_d, rd1_d, busy_d, done_d);
            else pass_cnt++;
        end
    endtask

    task automatic test_write_read();
        wr_en = 1'b1; add_wr = 3'd3; wr_data = 8'hA5;
        tick();
        add_wr = 3'd6; wr_data = 8'h5A;
        tick();
        wr_en = 1'b0; add_rd0 = 3'd3; add_rd1 = 3'd6;
        tick();
        total_cnt++;
        if (rd0_d !== 8'hA5 || rd1_d !== 8'h5A)
            $display("FAIL dual_read: rd0=%h rd1=%h, want a5 5a", rd0_d, rd1_d);
        else pass_cnt++;
        total_cnt++;
        if (rd0_nb !== 8'hA5 || rd1_nb !== 8'h5A)
            $display("FAIL dual_read_nb: rd0=%h rd1=%h, want a5 5a", rd0_nb, rd1_nb);
        else pass_cnt++;
        add_rd1 = 3'd3;
        tick();
        total_cnt++;
        if (rd0_d !== 8'hA5 || rd1_d !== 8'hA5)
            $display("FAIL same_addr: rd0=%h rd1=%h, want a5 a5", rd0_d, rd1_d);
        else pass_cnt++;
    endtask

    task automatic test_bypass();
        wr_en = 1'b1; add_wr = 3'd2; wr_data = 8'h11;
        tick();
        wr_data = 8'h3C; add_rd0 = 3'd2; add_rd1 = 3'd2;
        tick();
        total_cnt++;
        if (rd0_d !== 8'h3C || rd1_d !== 8'h3C)
            $display("FAIL bypass_on: rd0=%h rd1=%h, want 3c 3c", rd0_d, rd1_d);
        else pass_cnt++;
        total_cnt++;
        if (rd0_nb !== 8'h11 || rd1_nb !== 8'h11)
            $display("FAIL bypass_off: rd0=%h rd1=%h, want 11 11", rd0_nb, rd1_nb);
        else pass_cnt++;
        wr_en = 1'b0;
        tick();
        total_cnt++;
        if (rd0_nb !== 8'h3C)
            $display("FAIL bypass_off_next: rd0=%h, want 3c", rd0_nb);
        else pass_cnt++;
    endtask

    task automatic test_zero_reg();
        wr_en = 1'b1; add_wr = 3'd0; wr_data = 8'hFF; add_rd0 = 3'd0; add_rd1 = 3'd0;
        tick();
        total_cnt++;
        if (rd0_zr !== 8'h00 || rd1_zr !== 8'h00)
            $display("FAIL zero_bypass: rd0=%h rd1=%h, want 00 00", rd0_zr, rd1_zr);
        else pass_cnt++;
        add_wr = 3'd1;
        tick();
        wr_en = 1'b0; add_rd1 = 3'd1;
        tick();
        total_cnt++;
        if (rd0_zr !== 8'h00 || rd1_zr !== 8'hFF)
            $display("FAIL zero_reg: rd0=%h rd1=%h, want 00 ff", rd0_zr, rd1_zr);
        else pass_cnt++;
        total_cnt++;
        if (rd0_d !== 8'hFF)
            $display("FAIL zero_reg_off: rd0=%h, want ff", rd0_d);
        else pass_cnt++;
    endtask

    task automatic test_soft_clear();
        int busy_cycles;
        fill();
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        busy_cycles = busy_d ? 1 : 0;
        total_cnt++;
        if (busy_d !== 1'b1 || done_d !== 1'b0)
            $display("FAIL clear_enter: busy=%b done=%b, want 1 0", busy_d, done_d);
        else pass_cnt++;
        add_rd1 = 3'd7;
        for (int k = 1; k <= 8; k++) begin
            wr_en   = (k == 1);
            add_wr  = 3'd7;
            wr_data = 8'h77;
            add_rd0 = (k == 5) ? 3'd4 : 3'd1;
            tick();
            if (busy_d) busy_cycles++;
            total_cnt++;
            if (busy_d !== (k < 8) || done_d !== (k == 8))
                $display("FAIL clear_seq[%0d]: busy=%b done=%b, want %b %b",
                         k, busy_d, done_d, k < 8, k == 8);
            else pass_cnt++;
            total_cnt++;
            if (rd1_d !== ((k < 8) ? 8'h87 : 8'h00))
                $display("FAIL clear_drop[%0d]: rd1=%h, want %h", k, rd1_d, (k < 8) ? 8'h87 : 8'h00);
            else pass_cnt++;
            if (k == 5) begin
                total_cnt++;
                if (rd0_d !== 8'h00 || rd0_nb !== 8'h84)
                    $display("FAIL clear_bypass: rd0=%h rd0_nb=%h, want 00 84", rd0_d, rd0_nb);
                else pass_cnt++;
            end
        end
        wr_en = 1'b0;
        total_cnt++;
        if (busy_cycles !== 8)
            $display("FAIL busy_len: got %0d cycles, want 8", busy_cycles);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (done_d !== 1'b0 || busy_d !== 1'b0)
            $display("FAIL done_pulse: done=%b busy=%b, want 0 0", done_d, busy_d);
        else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            add_rd0 = 3'(i);
            add_rd1 = 3'(i);
            tick();
            total_cnt++;
            if (rd0_d !== 8'h00 || rd1_d !== 8'h00)
                $display("FAIL clear_readback[%0d]: rd0=%h rd1=%h, want 00 00", i, rd0_d, rd1_d);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_clear();
        bit saw_done;
        int busy_cycles;
        bit finished;
        fill();
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        tick();
        tick();
        total_cnt++;
        if (busy_d !== 1'b1)
            $display("FAIL abort_pre: busy=%b, want 1", busy_d);
        else pass_cnt++;
        reset = 1'b1; clr_start = 1'b1; wr_en = 1'b1; add_wr = 3'd5; wr_data = 8'h55;
        tick();
        reset = 1'b0; clr_start = 1'b0; wr_en = 1'b0;
        total_cnt++;
        if (busy_d !== 1'b0 || done_d !== 1'b0 || rd0_d !== 8'h00)
            $display("FAIL abort: busy=%b done=%b rd0=%h, want 0 0 00", busy_d, done_d, rd0_d);
        else pass_cnt++;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            add_rd0 = 3'(i % 8);
            add_rd1 = 3'(7 - (i % 8));
            tick();
            if (done_d !== 1'b0 || busy_d !== 1'b0) saw_done = 1'b1;
            total_cnt++;
            if (rd0_d !== 8'h00 || rd1_d !== 8'h00)
                $display("FAIL abort_readback[%0d]: rd0=%h rd1=%h, want 00 00", i, rd0_d, rd1_d);
            else pass_cnt++;
        end
        total_cnt++;
        if (saw_done !== 1'b0)
            $display("FAIL abort_no_done: saw busy/done=%b, want 0", saw_done);
        else pass_cnt++;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        busy_cycles = busy_d ? 1 : 0;
        finished = 1'b0;
        for (int i = 0; i < 20 && !finished; i++) begin
            tick();
            if (busy_d) busy_cycles++;
            if (done_d) finished = 1'b1;
        end
        total_cnt++;
        if (!finished || busy_cycles !== 8)
            $display("FAIL restart_clear: done_seen=%b busy_cycles=%0d, want 1 8", finished, busy_cycles);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_soft_clear();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
